// File: rtl/clk_tap_sync.sv
`default_nettype none
// ============================================================================
// Module   : clk_tap_sync
// Brief    : Re-synchronises divided-clock taps into clk-domain rise/fall
//            strobes and flags per-tap lock on the expected period.
//            Optional fall strobes: define CLK_TAP_SYNC_FALL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clk_tap_sync #(
    parameter int                  N_TAPS      = 4,
    parameter logic [5*N_TAPS-1:0] DIV_LOG2    = {5'd18, 5'd9, 5'd8, 5'd5},
    parameter int                  SYNC_STAGES = 2,
    parameter int                  CNT_W       = 20,
    parameter int                  TOL         = 1,
    parameter int                  LOCK_COUNT  = 2,
    localparam int                 c_SEL_W     = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic [N_TAPS-1:0]  tap_in,
    output logic [N_TAPS-1:0]  rise_stb,
    output logic [N_TAPS-1:0]  fall_stb,
    output logic [N_TAPS-1:0]  locked,
    output logic               all_locked,
    input  logic [c_SEL_W-1:0] meas_sel,
    output logic [CNT_W-1:0]   meas_period
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_MEASURE = 2'd1;
    localparam logic [1:0] c_LOCKED  = 2'd2;

    logic [CNT_W-1:0] w_last [N_TAPS];

    for (genvar i = 0; i < N_TAPS; i++) begin : g_tap
        localparam logic [CNT_W:0] c_EXP   = {{CNT_W{1'b0}}, 1'b1} << DIV_LOG2[5*i +: 5];
        localparam logic [CNT_W:0] c_TOL   = (CNT_W+1)'(TOL);
        localparam logic [CNT_W:0] c_LIMIT = c_EXP + c_TOL;

        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_d;
        logic                   r_rise;
        logic [CNT_W-1:0]       r_cnt;
        logic [CNT_W-1:0]       r_last;
        logic [3:0]             r_match_cnt;
        logic [1:0]             r_state;
        logic                   r_locked;
        logic                   w_s;
        logic [CNT_W:0]         w_cnt_ext;
        logic [CNT_W:0]         w_diff;
        logic                   w_match;
        logic                   w_timeout;
`ifdef CLK_TAP_SYNC_FALL_EN
        logic                   r_fall;
`endif

        assign w_s       = r_sync[SYNC_STAGES-1];
        assign w_cnt_ext = {1'b0, r_cnt};
        assign w_diff    = (w_cnt_ext >= c_EXP) ? (w_cnt_ext - c_EXP) : (c_EXP - w_cnt_ext);
        assign w_match   = (w_diff <= c_TOL);
        assign w_timeout = (w_cnt_ext > c_LIMIT);

        always_ff @(posedge clk or negedge arstn) begin
            if (!arstn) begin
                r_sync      <= '0;
                r_d         <= 1'b0;
                r_rise      <= 1'b0;
                r_cnt       <= '0;
                r_last      <= '0;
                r_match_cnt <= 4'd0;
                r_state     <= c_IDLE;
                r_locked    <= 1'b0;
`ifdef CLK_TAP_SYNC_FALL_EN
                r_fall      <= 1'b0;
`endif
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], tap_in[i]};
                r_d    <= w_s;
                r_rise <= w_s & ~r_d;
`ifdef CLK_TAP_SYNC_FALL_EN
                r_fall <= ~w_s & r_d;
`endif
                // The counter value on the strobe cycle is the measured period
                if (r_rise) begin
                    r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (r_cnt != {CNT_W{1'b1}}) begin
                    r_cnt <= r_cnt + 1'b1;
                end

                case (r_state)
                    c_IDLE: begin
                        if (r_rise) begin
                            r_state     <= c_MEASURE;
                            r_match_cnt <= 4'd0;
                        end
                    end
                    c_MEASURE: begin
                        if (r_rise) begin
                            r_last <= r_cnt;
                            if (w_match) begin
                                r_match_cnt <= r_match_cnt + 4'd1;
                                if (r_match_cnt == 4'(LOCK_COUNT - 1)) begin
                                    r_state  <= c_LOCKED;
                                    r_locked <= 1'b1;
                                end
                            end else begin
                                r_match_cnt <= 4'd0;
                            end
                        end
                    end
                    c_LOCKED: begin
                        if (r_rise) begin
                            r_last <= r_cnt;
                            if (!w_match) begin
                                r_state     <= c_MEASURE;
                                r_match_cnt <= 4'd0;
                                r_locked    <= 1'b0;
                            end
                        end else if (w_timeout) begin
                            r_state     <= c_MEASURE;
                            r_match_cnt <= 4'd0;
                            r_locked    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= c_IDLE;
                        r_match_cnt <= 4'd0;
                        r_locked    <= 1'b0;
                    end
                endcase
            end
        end

        assign rise_stb[i] = r_rise;
        assign locked[i]   = r_locked;
        assign w_last[i]   = r_last;
`ifdef CLK_TAP_SYNC_FALL_EN
        assign fall_stb[i] = r_fall;
`else
        assign fall_stb[i] = 1'b0;
`endif
    end : g_tap

    assign all_locked = &locked;

    always_comb begin
        meas_period = w_last[0];
        if (32'(meas_sel) < N_TAPS) begin
            meas_period = w_last[meas_sel];
        end
    end

endmodule : clk_tap_sync
`default_nettype wire

// File: tb/tb_clk_tap_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_tap_sync
// Brief    : Scoreboard bench for clk_tap_sync; tap 0 is driven by directed
//            pulses, taps 1..3 free-run at their nominal periods.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_tap_sync;

    localparam int N  = 4;
    localparam int CW = 7;
`ifdef CLK_TAP_SYNC_FALL_EN
    localparam logic c_FALL_EXP = 1'b1;
`else
    localparam logic c_FALL_EXP = 1'b0;
`endif

    typedef struct {
        int           cyc;
        logic [CW-1:0] per;
        logic          lk;
    } exp_t;

    logic          clk   = 1'b0;
    logic          arstn = 1'b0;
    logic          tap0  = 1'b0;
    logic [7:0]    gen   = 8'd0;
    logic [N-1:0]  tap_in;
    logic [N-1:0]  rise_stb;
    logic [N-1:0]  fall_stb;
    logic [N-1:0]  locked;
    logic          all_locked;
    logic [1:0]    meas_sel = 2'd0;
    logic [CW-1:0] meas_period;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_k = 0;
    exp_t rq[$];
    int   fq[$];
    logic pend = 1'b0;
    exp_t pexp;

    // Taps 1..3 run at exactly 16, 64 and 8 cycles
    assign tap_in = {gen[2], gen[5], gen[3], tap0};

    clk_tap_sync #(
        .N_TAPS      (N),
        .DIV_LOG2    ({5'd3, 5'd6, 5'd4, 5'd5}),
        .SYNC_STAGES (2),
        .CNT_W       (CW),
        .TOL         (1),
        .LOCK_COUNT  (2)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .tap_in      (tap_in),
        .rise_stb    (rise_stb),
        .fall_stb    (fall_stb),
        .locked      (locked),
        .all_locked  (all_locked),
        .meas_sel    (meas_sel),
        .meas_period (meas_period)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            gen = gen + 8'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Rise on tap0 now, fall after hi cycles; next call rises hi+lo after this one
    task automatic pulse0(input int hi, input int lo, input logic [CW-1:0] per, input logic lk);
        exp_t e;
        @(posedge clk);
        #1;
        tap0   = 1'b1;
        last_k = cyc;
        e.cyc  = cyc + 3;
        e.per  = per;
        e.lk   = lk;
        rq.push_back(e);
        repeat (hi) @(posedge clk);
        #1;
        tap0 = 1'b0;
        fq.push_back(cyc + 3);
        repeat (lo - 1) @(posedge clk);
    endtask

    // Monitor: strobe timing, then period/lock one cycle after each rise strobe
    always @(negedge clk) begin
        if (pend) begin
            chk("meas_period", 32'(meas_period), 32'(pexp.per));
            chk("locked0", 32'(locked[0]), 32'(pexp.lk));
            pend = 1'b0;
        end
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            pexp = rq.pop_front();
            chk("rise_stb0", 32'(rise_stb[0]), 32'd1);
            pend = 1'b1;
        end else if (rise_stb[0]) begin
            checks++;
            errors++;
            $display("FAIL rise_stb0_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end
        if (fq.size() > 0 && fq[0] == cyc) begin
            void'(fq.pop_front());
            chk("fall_stb0", 32'(fall_stb[0]), 32'(c_FALL_EXP));
        end else if (fall_stb[0]) begin
            checks++;
            errors++;
            $display("FAIL fall_stb0_unexpected: got 1 expected 0 (cycle %0d)", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] tab [4];
        int k;
        tab[0] = 7'd32; tab[1] = 7'd16; tab[2] = 7'd64; tab[3] = 7'd8;

        // Reset held while taps toggle
        repeat (12) begin
            @(posedge clk);
            #1;
            tap0 = ~tap0;
        end
        @(negedge clk);
        chk("rst_rise", 32'(rise_stb), 32'd0);
        chk("rst_fall", 32'(fall_stb), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_all_locked", 32'(all_locked), 32'd0);
        for (int s = 0; s < 4; s++) begin
            meas_sel = 2'(s);
            #1;
            chk("rst_meas_period", 32'(meas_period), 32'd0);
        end
        meas_sel = 2'd0;
        tap0     = 1'b0;
        @(posedge clk);
        #2;
        arstn = 1'b1;

        // Lock acquisition at period 32
        pulse0(16, 16, 7'd0, 1'b0);
        pulse0(16, 16, 7'd32, 1'b0);
        pulse0(16, 16, 7'd32, 1'b1);
        repeat (7) pulse0(16, 16, 7'd32, 1'b1);
        @(negedge clk);
        chk("all_taps_locked", 32'(locked), 32'hF);
        chk("all_locked_high", 32'(all_locked), 32'd1);

        // Stuck low: lock drops the cycle after cnt reaches 34
        k = last_k;
        while (cyc < k + 37) @(negedge clk);
        chk("lock_before_timeout", 32'(locked[0]), 32'd1);
        @(negedge clk);
        chk("lock_after_timeout", 32'(locked[0]), 32'd0);
        chk("all_locked_timeout", 32'(all_locked), 32'd0);
        for (int s = 1; s < 4; s++) begin
            meas_sel = 2'(s);
            #1;
            chk("meas_sel_period", 32'(meas_period), 32'(tab[s]));
        end
        meas_sel = 2'd0;
        #1;
        chk("meas_sel0_period", 32'(meas_period), 32'(tab[0]));
        while (cyc < k + 199) @(negedge clk);
        pulse0(16, 16, 7'd127, 1'b0);
        pulse0(16, 16, 7'd32, 1'b0);
        pulse0(16, 16, 7'd32, 1'b1);

        // Wrong period 40 never locks
        pulse0(20, 20, 7'd32, 1'b1);
        repeat (3) pulse0(20, 20, 7'd40, 1'b0);
        @(negedge clk);
        chk("lock_period40", 32'(locked[0]), 32'd0);
        chk("all_locked_period40", 32'(all_locked), 32'd0);
        chk("meas_period40", 32'(meas_period), 32'd40);
        pulse0(16, 16, 7'd40, 1'b0);
        pulse0(16, 16, 7'd32, 1'b0);
        pulse0(16, 17, 7'd32, 1'b1);
        pulse0(16, 16, 7'd33, 1'b1);
        pulse0(16, 16, 7'd32, 1'b1);
        @(negedge clk);
        chk("locked_before_reset", 32'(locked), 32'hF);

        // Asynchronous reset pulse while locked
        #2;
        arstn = 1'b0;
        #1;
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_all_locked", 32'(all_locked), 32'd0);
        chk("async_meas_period", 32'(meas_period), 32'd0);
        chk("async_rise", 32'(rise_stb), 32'd0);
        @(posedge clk);
        #3;
        arstn = 1'b1;
        pulse0(16, 16, 7'd0, 1'b0);
        pulse0(16, 16, 7'd32, 1'b0);
        pulse0(16, 16, 7'd32, 1'b1);
        @(negedge clk);
        chk("relock_after_reset", 32'(locked[0]), 32'd1);

        repeat (10) @(negedge clk);
        chk("rise_queue_drained", 32'(rq.size()), 32'd0);
        chk("fall_queue_drained", 32'(fq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_clk_tap_sync
`default_nettype wire
